// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: serial transmitter matching the oversampled UART receiver.
// Frame = start bit (0), DATA_WIDTH data bits LSB first, optional parity
// bit, one stop bit (1). Each bit lasts P clock cycles, where P is the
// prescale latched when the byte is accepted (8, 16 or 32; other values
// fall back to 8).
//
// Handshake: a byte is accepted on the rising edge where DATA_VALID=1 and
// busy=0. busy rises on that same edge and stays high until the edge that
// returns the FSM to IDLE. DATA_VALID while busy=1 is ignored, with no
// queueing. At least one idle cycle separates two frames.
module uart_tx_fsm #(
  parameter int DATA_WIDTH  = 8,
  parameter int scale_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   DATA_VALID,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic [scale_WIDTH-1:0] prescaler,
  output logic                   TX_OUT,
  output logic                   busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Registered state
  state_t                 state;
  logic [scale_WIDTH-1:0] edge_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic [scale_WIDTH-1:0] p_q;
  logic                   par_en_q;
  logic                   par_bit_q;

  // Next-state values
  state_t                 state_next;
  logic [scale_WIDTH-1:0] edge_cnt_next;
  logic [BW-1:0]          bit_cnt_next;
  logic [DATA_WIDTH-1:0]  shift_next;
  logic [scale_WIDTH-1:0] p_next;
  logic                   par_en_next;
  logic                   par_bit_next;
  logic                   tx_next;
  logic                   busy_next;

  // Helpers
  logic [scale_WIDTH-1:0] p_eff;
  logic                   bit_done;
  logic                   last_data_bit;
  logic [DATA_WIDTH-1:0]  shifted;

  // Map the prescaler input onto a legal bit period (8, 16 or 32).
  always_comb begin
    p_eff = scale_WIDTH'(8);
    if ((prescaler == scale_WIDTH'(16)) || (prescaler == scale_WIDTH'(32))) begin
      p_eff = prescaler;
    end
  end

  // The current bit has been held for P cycles when the edge counter
  // reaches P-1; the next edge is a bit boundary.
  assign bit_done      = (edge_cnt == (p_q - scale_WIDTH'(1)));
  assign last_data_bit = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign shifted       = shift_reg >> 1;

  // Next-state and registered-output logic. TX_OUT and busy are computed
  // one cycle ahead so that they leave the flops on the same edge the FSM
  // changes state, which keeps the line glitch-free.
  always_comb begin
    state_next    = state;
    edge_cnt_next = edge_cnt;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift_reg;
    p_next        = p_q;
    par_en_next   = par_en_q;
    par_bit_next  = par_bit_q;
    tx_next       = TX_OUT;
    busy_next     = busy;

    unique case (state)
      IDLE: begin
        tx_next       = 1'b1;
        busy_next     = 1'b0;
        edge_cnt_next = '0;
        bit_cnt_next  = '0;
        if (DATA_VALID) begin
          // Latch everything the frame needs; later input changes are
          // ignored until the frame completes. Parity is computed here
          // because the shift register is consumed as the bits go out.
          shift_next    = P_DATA;
          p_next        = p_eff;
          par_en_next   = PAR_EN;
          par_bit_next  = (^P_DATA) ^ PAR_TYP;
          state_next    = START;
          tx_next       = 1'b0;
          busy_next     = 1'b1;
        end
      end

      START: begin
        if (bit_done) begin
          edge_cnt_next = '0;
          state_next    = DATA;
          tx_next       = shift_reg[0];
        end else begin
          edge_cnt_next = edge_cnt + scale_WIDTH'(1);
        end
      end

      DATA: begin
        if (bit_done) begin
          edge_cnt_next = '0;
          if (last_data_bit) begin
            bit_cnt_next = '0;
            if (par_en_q) begin
              state_next = PARITY;
              tx_next    = par_bit_q;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
            shift_next   = shifted;
            tx_next      = shifted[0];
          end
        end else begin
          edge_cnt_next = edge_cnt + scale_WIDTH'(1);
        end
      end

      PARITY: begin
        if (bit_done) begin
          edge_cnt_next = '0;
          state_next    = STOP;
          tx_next       = 1'b1;
        end else begin
          edge_cnt_next = edge_cnt + scale_WIDTH'(1);
        end
      end

      STOP: begin
        tx_next = 1'b1;
        if (bit_done) begin
          // busy drops on the edge that enters IDLE, so IDLE always lasts
          // at least one cycle before another byte can be accepted.
          edge_cnt_next = '0;
          state_next    = IDLE;
          busy_next     = 1'b0;
        end else begin
          edge_cnt_next = edge_cnt + scale_WIDTH'(1);
        end
      end

      default: begin
        state_next    = IDLE;
        edge_cnt_next = '0;
        bit_cnt_next  = '0;
        tx_next       = 1'b1;
        busy_next     = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset; reset wins over DATA_VALID and
  // abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      p_q       <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      edge_cnt  <= edge_cnt_next;
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
      p_q       <= p_next;
      par_en_q  <= par_en_next;
      par_bit_q <= par_bit_next;
      TX_OUT    <= tx_next;
      busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Testbench for uart_tx_fsm: a driver issues bytes, a reference model turns
// each accepted byte into the expected frame (bit list, bit period, gap
// requirement) pushed on exp_q, and a monitor decodes the serial line and
// compares each received frame against the queue head.
module tb_uart_tx_fsm;

  localparam int DW = 8;
  localparam int SW = 6;
  localparam int W  = 27; // {gap[26], p[25:20], nbits[19:16], bits[15:0]}

  logic          clk;
  logic          reset;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [SW-1:0] prescaler;
  logic          TX_OUT;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];

  uart_tx_fsm #(.DATA_WIDTH(DW), .scale_WIDTH(SW)) dut (
    .clk        (clk),
    .reset      (reset),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescaler  (prescaler),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- shared check ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame as a list of line levels, one per bit, plus bit period.
  function automatic logic [W-1:0] model(input logic [DW-1:0] d, input bit pe, input bit pt,
                                         input logic [SW-1:0] ps, input bit gap);
    int p;
    int n;
    logic [15:0] b;
    p = (ps == 8 || ps == 16 || ps == 32) ? int'(ps) : 8;
    b = '0;
    n = 0;
    b[n] = 1'b0; n++;                       // start
    for (int i = 0; i < DW; i++) begin      // data, LSB first
      b[n] = d[i]; n++;
    end
    if (pe) begin                           // even: 1 when odd count of ones
      b[n] = (($countones(d) % 2) == 1) ? ~pt : pt; n++;
    end
    b[n] = 1'b1; n++;                       // stop
    return {gap, 6'(p), 4'(n), b};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] mon_exp;
  bit           mon_active = 0;
  bit           mon_skip   = 0;
  int           mon_cyc    = 0;
  logic [15:0]  seen;
  bit           glitch     = 0;
  int           idle_cnt   = 0;
  bit           rst_prev   = 0;

  always @(negedge clk) begin
    int p;
    int nb;
    int idx;
    logic [15:0] mask;
    if (rst_prev) begin
      // A reset edge has just occurred: line must be idle, frame abandoned.
      check("reset_out", {30'd0, TX_OUT, busy}, 32'h2);
      mon_active = 0;
      idle_cnt   = 0;
    end else if (mon_active) begin
      p  = int'(mon_exp[25:20]);
      nb = int'(mon_exp[19:16]);
      if (busy === 1'b1) begin
        if (p > 0) begin
          idx = mon_cyc / p;
          if (idx < 16) begin
            if ((mon_cyc % p) == 0) seen[idx] = TX_OUT;
            else if (TX_OUT !== seen[idx]) glitch = 1;
          end
        end
        mon_cyc++;
      end else begin
        if (!mon_skip) begin
          mask = 16'((32'd1 << nb) - 1);
          check("frame_len",  32'(mon_cyc), 32'(nb * p));
          check("frame_bits", {16'd0, seen & mask}, {16'd0, mon_exp[15:0]});
          check("tx_stable",  {31'd0, glitch}, 32'd0);
          check("idle_tx",    {31'd0, TX_OUT}, 32'd1);
        end
        mon_active = 0;
        idle_cnt   = 1;
      end
    end else if (busy === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'(exp_q.size()), 32'd1);
        mon_skip = 1;
        mon_exp  = '0;
      end else begin
        mon_skip = 0;
        mon_exp  = exp_q.pop_front();
        if (mon_exp[26]) check("idle_gap", 32'(idle_cnt), 32'd1);
      end
      seen       = '0;
      seen[0]    = TX_OUT;
      glitch     = 0;
      mon_cyc    = 1;
      mon_active = 1;
    end else begin
      idle_cnt++;
    end
    rst_prev = reset;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] d, input bit pe, input bit pt, input logic [SW-1:0] ps);
    @(posedge clk); #1;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    prescaler  = ps;
    DATA_VALID = 1'b1;
    exp_q.push_back(model(d, pe, pt, ps, 1'b0));
    @(posedge clk); #1;
    DATA_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (((busy !== 1'b0) || mon_active) && (t < 3000));
    n_cmp++;
    if (t >= 3000) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, t);
    end
  endtask

  task automatic wait_busy_low();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy !== 1'b0) && (t < 3000));
    n_cmp++;
    if (t >= 3000) begin
      n_fail++;
      $display("FAIL busy_low_timeout: busy=%b after %0d cycles, required 0", busy, t);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b1;
    P_DATA     = '0;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    prescaler  = 6'd8;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);

    // Directed frames
    send(8'hA5, 1'b0, 1'b0, 6'd8);  wait_idle();
    send(8'hA5, 1'b1, 1'b0, 6'd16); wait_idle();
    send(8'hA5, 1'b1, 1'b1, 6'd16); wait_idle();
    send(8'h01, 1'b1, 1'b1, 6'd32); wait_idle();

    // DATA_VALID held high: two frames, one idle cycle apart; a later
    // mid-frame pulse must be ignored.
    @(posedge clk); #1;
    P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescaler = 6'd8; DATA_VALID = 1'b1;
    exp_q.push_back(model(8'h55, 1'b0, 1'b0, 6'd8, 1'b0));
    exp_q.push_back(model(8'h0F, 1'b0, 1'b0, 6'd8, 1'b1));
    @(posedge clk); #1;
    P_DATA = 8'h0F;
    wait_busy_low();
    @(posedge clk); #1;
    DATA_VALID = 1'b0;
    repeat (20) @(posedge clk); #1;
    P_DATA = 8'hFF; DATA_VALID = 1'b1;
    @(posedge clk); #1;
    DATA_VALID = 1'b0;
    wait_idle();
    repeat (5) @(posedge clk);

    // Illegal prescaler falls back to 8; mid-frame change has no effect.
    send(8'h3C, 1'b0, 1'b0, 6'd5);
    repeat (20) @(posedge clk); #1;
    prescaler = 6'd16;
    wait_idle();

    // Reset during data bit 3 (frame cycles 32..39).
    send(8'hC3, 1'b0, 1'b0, 6'd8);
    repeat (34) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    send(8'h96, 1'b1, 1'b0, 6'd8);
    wait_idle();

    // Randomized frames with mid-frame input disturbance.
    for (int k = 0; k < 30; k++) begin
      logic [SW-1:0] ps;
      case ($urandom_range(0, 3))
        0: ps = 6'd8;
        1: ps = 6'd16;
        2: ps = 6'd32;
        default: ps = 6'($urandom_range(0, 63));
      endcase
      send(8'($urandom), 1'($urandom), 1'($urandom), ps);
      repeat ($urandom_range(3, 40)) @(posedge clk); #1;
      P_DATA    = 8'($urandom);
      PAR_EN    = 1'($urandom);
      PAR_TYP   = 1'($urandom);
      prescaler = 6'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        DATA_VALID = 1'b1;
        @(posedge clk); #1;
        DATA_VALID = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end

    repeat (10) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
UART serial transmitter: the transmit-side counterpart of the team's oversampled UART receiver, sharing its frame format and prescale settings.
- Accepts one parallel byte per valid/busy handshake and shifts it out LSB-first on TX_OUT.
- Frame: start bit, data bits, optional parity bit, one stop bit.
- Each bit lasts `prescaler` clock cycles, so the block runs on the same oversampled clock as the receiver.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- scale_WIDTH, 6, width of the prescaler input.

Ports:
- clk, input, 1, oversampled UART clock (all logic on rising edge).
- reset, input, 1, synchronous active-high reset.
- P_DATA, input, DATA_WIDTH, parallel byte to send.
- DATA_VALID, input, 1, P_DATA is valid; a transfer is accepted when DATA_VALID=1 and busy=0.
- PAR_EN, input, 1, 1 = parity bit inserted after the data bits.
- PAR_TYP, input, 1, 0 = even parity, 1 = odd parity.
- prescaler, input, scale_WIDTH, clock cycles per bit; legal values 8, 16, 32.
- TX_OUT, output, 1, serial line, registered, idles high.
- busy, output, 1, registered; high while a frame is in progress.

Behaviour:
- One clock domain. Reset is synchronous and active-high. The clock is clk and the reset is reset.
- Reset values: TX_OUT=1, busy=0, FSM=IDLE, bit and edge counters=0, shift register=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - If DATA_VALID=1 in cycle N, latch P_DATA, PAR_EN, PAR_TYP and the effective prescale P, then go to START.
  - From edge N+1: TX_OUT=0 and busy=1.
- Illegal prescaler values (anything other than 8, 16, 32) are treated as P=8. The latched value is used for the whole frame; input changes mid-frame are ignored.
- Edge counter: runs 0..P-1 within each bit and wraps to 0 at the bit boundary. Every bit holds TX_OUT for exactly P cycles.
- START: drive 0 for P cycles, then go to DATA.
- DATA:
  - Drive shift-register bit 0, shift right at each bit boundary.
  - Bit counter counts 0..DATA_WIDTH-1.
  - After the last data bit: go to PARITY if the latched PAR_EN=1, else STOP.
- PARITY:
  - Drive parity for P cycles, then go to STOP.
  - Parity = XOR of the latched data when PAR_TYP=0.
  - Parity = XNOR of the latched data when PAR_TYP=1.
- STOP: drive 1 for P cycles, then go to IDLE. busy drops on the same edge the FSM enters IDLE.
- Frame length from acceptance edge to busy falling: (DATA_WIDTH+2+PAR_EN)*P cycles.
- Back-to-back frames: at least one IDLE cycle separates frames (TX_OUT=1, busy=0). If DATA_VALID is held high, the next frame is accepted in that IDLE cycle. The stop bit is effectively P+1 cycles.
- DATA_VALID while busy=1 is ignored. There is no queueing, and P_DATA changes do not affect the frame in flight.
- TX_OUT never glitches: it changes only at bit boundaries, on the acceptance edge, and on reset.
- Reset mid-frame: on the next clk edge TX_OUT=1, busy=0, FSM=IDLE, and the partial frame is abandoned.
- Reset has priority over a simultaneous DATA_VALID.

Test Plan:
- P=8, PAR_EN=0, P_DATA=0xA5, single DATA_VALID pulse -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 (LSB first), each level held 8 cycles; busy high for exactly 80 cycles.
- P=16, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5 -> parity bit 0, frame of 11 bits × 16 = 176 cycles. Repeat with PAR_TYP=1 -> parity bit 1.
- P=32, PAR_EN=1, PAR_TYP=1, P_DATA=0x01 -> parity bit 0; stop bit high for 32 cycles; busy falls at cycle 352.
- DATA_VALID held high with 0x55 then 0x0F, P=8, no parity -> two complete frames separated by exactly one high IDLE cycle. A third DATA_VALID pulse mid-frame with 0xFF is ignored.
- prescaler=6'd5, P_DATA=0x3C -> frame timed with 8 cycles per bit. Change prescaler to 16 mid-frame -> timing unchanged.
- reset asserted during data bit 3 of a frame -> TX_OUT=1 and busy=0 on the next edge. A new DATA_VALID two cycles after reset release starts a clean frame.
